// File: rtl/i_execute_if.sv
// EX-stage bus: ID/EX operands and controls in, EX/MEM pipeline register out.
// master = upstream/pipeline side, slave = the execute stage.
interface i_execute_if;
    logic        id_ex_valid;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] s_extend;
    logic [4:0]  instr_2016;
    logic [4:0]  instr_1511;
    logic        ex_flush;
    logic        ex_busy;
    logic [1:0]  EX_MEM_wb;
    logic [2:0]  EX_MEM_m;
    logic [31:0] EX_MEM_add_result;
    logic        EX_MEM_zero;
    logic [31:0] EX_MEM_alu_result;
    logic [31:0] EX_MEM_rdata2;
    logic [4:0]  EX_MEM_rd;

    modport master (
        output id_ex_valid, wb_ctl, m_ctl, regdst, alusrc, aluop, npc,
               rdata1, rdata2, s_extend, instr_2016, instr_1511, ex_flush,
        input  ex_busy, EX_MEM_wb, EX_MEM_m, EX_MEM_add_result, EX_MEM_zero,
               EX_MEM_alu_result, EX_MEM_rdata2, EX_MEM_rd
    );

    modport slave (
        input  id_ex_valid, wb_ctl, m_ctl, regdst, alusrc, aluop, npc,
               rdata1, rdata2, s_extend, instr_2016, instr_1511, ex_flush,
        output ex_busy, EX_MEM_wb, EX_MEM_m, EX_MEM_add_result, EX_MEM_zero,
               EX_MEM_alu_result, EX_MEM_rdata2, EX_MEM_rd
    );
endinterface

// File: rtl/i_execute.sv
// Execute stage: single-cycle ALU and branch adder, plus a 32-step shift-add
// multiplier that stalls upstream through ex_busy while it iterates.
module i_execute (
    input logic      clk,
    input logic      rst_n,
    i_execute_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add_result;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] rdata2;
        logic [4:0]  rd;
    } ex_mem_t;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;

    logic [5:0]  funct;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] target;
    logic [4:0]  dest;
    logic        is_mult;
    ex_mem_t     normal;
    ex_mem_t     ex_mem_q;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [1:0]  held_wb;
    logic [2:0]  held_m;
    logic [31:0] held_target;
    logic [31:0] held_rdata2;
    logic [4:0]  held_rd;

    assign funct   = bus.s_extend[5:0];
    assign alu_b   = bus.alusrc ? bus.s_extend : bus.rdata2;
    assign target  = bus.npc + {bus.s_extend[29:0], 2'b00};
    assign dest    = bus.regdst ? bus.instr_1511 : bus.instr_2016;
    assign is_mult = bus.id_ex_valid && (bus.aluop == 2'b10) && (funct == F_MULT);

    always_comb begin
        // NOTE: default first so every path assigns alu_y and no latch is inferred.
        alu_y = '0;
        case (bus.aluop)
            2'b01:   alu_y = bus.rdata1 - alu_b;
            2'b10: begin
                case (funct)
                    F_ADD:   alu_y = bus.rdata1 + alu_b;
                    F_SUB:   alu_y = bus.rdata1 - alu_b;
                    F_AND:   alu_y = bus.rdata1 & alu_b;
                    F_OR:    alu_y = bus.rdata1 | alu_b;
                    F_SLT:   alu_y = {31'd0, $signed(bus.rdata1) < $signed(alu_b)};
                    default: alu_y = '0;
                endcase
            end
            default: alu_y = bus.rdata1 + alu_b;
        endcase
    end

    assign normal = '{wb: bus.wb_ctl, m: bus.m_ctl, add_result: target,
                      zero: (alu_y == '0), alu_result: alu_y,
                      rdata2: bus.rdata2, rd: dest};

    // Flush wins over the stall so a squashed multiply never holds the pipe.
    assign bus.ex_busy = !bus.ex_flush &&
                         (((state == IDLE) && is_mult) || (state == MUL));

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous (only looked at on the clock edge); all state uses <=.
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            held_wb     <= '0;
            held_m      <= '0;
            held_target <= '0;
            held_rdata2 <= '0;
            held_rd     <= '0;
            ex_mem_q    <= '0;
        end else if (bus.ex_flush) begin
            state    <= IDLE;
            cnt      <= '0;
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= '0;
            case (state)
                IDLE: begin
                    if (is_mult) begin
                        mcand       <= bus.rdata1;
                        mplier      <= alu_b;
                        acc         <= '0;
                        held_wb     <= bus.wb_ctl;
                        held_m      <= bus.m_ctl;
                        held_target <= target;
                        held_rdata2 <= bus.rdata2;
                        held_rd     <= dest;
                        cnt         <= '0;
                        state       <= MUL;
                    end else if (bus.id_ex_valid) begin
                        ex_mem_q <= normal;
                    end
                end
                MUL: begin
                    // Two's complement: low 32 bits of the unsigned product equal the signed one.
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= DONE;
                end
                DONE: begin
                    ex_mem_q <= '{wb: held_wb, m: held_m, add_result: held_target,
                                  zero: (acc == '0), alu_result: acc,
                                  rdata2: held_rdata2, rd: held_rd};
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.EX_MEM_wb         = ex_mem_q.wb;
    assign bus.EX_MEM_m          = ex_mem_q.m;
    assign bus.EX_MEM_add_result = ex_mem_q.add_result;
    assign bus.EX_MEM_zero       = ex_mem_q.zero;
    assign bus.EX_MEM_alu_result = ex_mem_q.alu_result;
    assign bus.EX_MEM_rdata2     = ex_mem_q.rdata2;
    assign bus.EX_MEM_rd         = ex_mem_q.rd;
endmodule

// File: tb/tb_i_execute.sv
// Directed bench for i_execute: ALU ops, branch target, multi-cycle multiply,
// flush and reset during a multiply, each checked against hand-computed values.
module tb_i_execute;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    i_execute_if bus ();
    i_execute dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_ex_valid = 1'b0;
        bus.wb_ctl      = '0;
        bus.m_ctl       = '0;
        bus.regdst      = 1'b0;
        bus.alusrc      = 1'b0;
        bus.aluop       = '0;
        bus.npc         = '0;
        bus.rdata1      = '0;
        bus.rdata2      = '0;
        bus.s_extend    = '0;
        bus.instr_2016  = '0;
        bus.instr_1511  = '0;
        bus.ex_flush    = 1'b0;
    endtask

    task automatic present(input logic [1:0] wb, input logic [2:0] m,
                           input logic regdst, input logic alusrc,
                           input logic [1:0] aluop, input logic [31:0] npc,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] sext, input logic [4:0] rt,
                           input logic [4:0] rd);
        bus.id_ex_valid = 1'b1;
        bus.wb_ctl      = wb;
        bus.m_ctl       = m;
        bus.regdst      = regdst;
        bus.alusrc      = alusrc;
        bus.aluop       = aluop;
        bus.npc         = npc;
        bus.rdata1      = r1;
        bus.rdata2      = r2;
        bus.s_extend    = sext;
        bus.instr_2016  = rt;
        bus.instr_1511  = rd;
        bus.ex_flush    = 1'b0;
    endtask

    // R-type mult: -3 * 6, writes back to rd=7.
    task automatic present_mult();
        present(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h40, 32'hFFFF_FFFD, 32'd6,
                32'h0000_0018, 5'd4, 5'd7);
    endtask

    task automatic test_reset();
        present(2'b11, 3'b111, 1'b1, 1'b0, 2'b10, 32'h100, 32'd5, 32'd7,
                32'h20, 5'd3, 5'd9);
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({bus.EX_MEM_wb, bus.EX_MEM_m, bus.EX_MEM_add_result, bus.EX_MEM_zero,
             bus.EX_MEM_alu_result, bus.EX_MEM_rdata2, bus.EX_MEM_rd} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got wb=%b m=%b add=%h z=%b alu=%h rd2=%h rd=%0d required all 0",
                     bus.EX_MEM_wb, bus.EX_MEM_m, bus.EX_MEM_add_result, bus.EX_MEM_zero,
                     bus.EX_MEM_alu_result, bus.EX_MEM_rdata2, bus.EX_MEM_rd);
        end
        idle_inputs();
        #1;
        tests++;
        if (bus.ex_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b required 0", bus.ex_busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        present(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd5, 32'd7,
                32'h0000_0020, 5'd3, 5'd9);
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'd12 || bus.EX_MEM_zero !== 1'b0) begin
            fails++;
            $display("FAIL add_result: got alu=%h z=%b required 0000000c z=0",
                     bus.EX_MEM_alu_result, bus.EX_MEM_zero);
        end
        tests++;
        if (bus.EX_MEM_wb !== 2'b10 || bus.EX_MEM_rd !== 5'd9 || bus.EX_MEM_rdata2 !== 32'd7) begin
            fails++;
            $display("FAIL add_ctl: got wb=%b rd=%0d rd2=%h required wb=10 rd=9 rd2=7",
                     bus.EX_MEM_wb, bus.EX_MEM_rd, bus.EX_MEM_rdata2);
        end
    endtask

    task automatic test_branch();
        present(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h100, 32'd9, 32'd9,
                32'd4, 5'd2, 5'd0);
        tick();
        tests++;
        if (bus.EX_MEM_zero !== 1'b1 || bus.EX_MEM_add_result !== 32'h110 ||
            bus.EX_MEM_m !== 3'b100) begin
            fails++;
            $display("FAIL branch: got z=%b add=%h m=%b required z=1 add=00000110 m=100",
                     bus.EX_MEM_zero, bus.EX_MEM_add_result, bus.EX_MEM_m);
        end
    endtask

    task automatic test_slt();
        present(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'd1,
                32'h0000_002A, 5'd1, 5'd2);
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'd1 || bus.EX_MEM_zero !== 1'b0) begin
            fails++;
            $display("FAIL slt_neg_lt_pos: got alu=%h z=%b required 00000001 z=0",
                     bus.EX_MEM_alu_result, bus.EX_MEM_zero);
        end
        bus.rdata1 = 32'd1;
        bus.rdata2 = 32'hFFFF_FFFF;
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'd0 || bus.EX_MEM_zero !== 1'b1) begin
            fails++;
            $display("FAIL slt_pos_lt_neg: got alu=%h z=%b required 00000000 z=1",
                     bus.EX_MEM_alu_result, bus.EX_MEM_zero);
        end
    endtask

    task automatic test_back_to_back();
        // sub wrapping below zero
        present(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd3, 32'd5,
                32'h0000_0022, 5'd1, 5'd10);
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'hFFFF_FFFE || bus.EX_MEM_rd !== 5'd10) begin
            fails++;
            $display("FAIL sub_wrap: got alu=%h rd=%0d required fffffffe rd=10",
                     bus.EX_MEM_alu_result, bus.EX_MEM_rd);
        end
        present(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0000_F0F0, 32'h0000_FF00,
                32'h0000_0024, 5'd1, 5'd11);
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'h0000_F000) begin
            fails++;
            $display("FAIL and: got %h required 0000f000", bus.EX_MEM_alu_result);
        end
        bus.s_extend = 32'h0000_0025;
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'h0000_FFF0) begin
            fails++;
            $display("FAIL or: got %h required 0000fff0", bus.EX_MEM_alu_result);
        end
        present(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd5, 32'd7,
                32'h0000_003F, 5'd1, 5'd12);
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'd0 || bus.EX_MEM_zero !== 1'b1) begin
            fails++;
            $display("FAIL unknown_funct: got alu=%h z=%b required 00000000 z=1",
                     bus.EX_MEM_alu_result, bus.EX_MEM_zero);
        end
        // I-type add with negative immediate; dest from rt; target wraps below npc
        present(2'b10, 3'b000, 1'b0, 1'b1, 2'b11, 32'h20, 32'd10, 32'd99,
                32'hFFFF_FFFC, 5'd13, 5'd30);
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'd6 || bus.EX_MEM_rd !== 5'd13 ||
            bus.EX_MEM_add_result !== 32'h10) begin
            fails++;
            $display("FAIL imm_add: got alu=%h rd=%0d add=%h required 00000006 rd=13 add=00000010",
                     bus.EX_MEM_alu_result, bus.EX_MEM_rd, bus.EX_MEM_add_result);
        end
        // aluop 00 with a target whose shifted-out top bits must be dropped
        present(2'b01, 3'b010, 1'b0, 1'b1, 2'b00, 32'hFFFF_FFFC, 32'd1, 32'd0,
                32'h4000_0001, 5'd14, 5'd0);
        tick();
        tests++;
        if (bus.EX_MEM_add_result !== 32'h0 || bus.EX_MEM_alu_result !== 32'h4000_0002 ||
            bus.EX_MEM_m !== 3'b010) begin
            fails++;
            $display("FAIL lw_target_wrap: got add=%h alu=%h m=%b required 00000000 40000002 m=010",
                     bus.EX_MEM_add_result, bus.EX_MEM_alu_result, bus.EX_MEM_m);
        end
        bus.id_ex_valid = 1'b0;
        tick();
        tests++;
        if (bus.EX_MEM_wb !== 2'b00 || bus.EX_MEM_m !== 3'b000) begin
            fails++;
            $display("FAIL bubble: got wb=%b m=%b required 00 000", bus.EX_MEM_wb, bus.EX_MEM_m);
        end
    endtask

    task automatic test_mult();
        int busy_cycles = 0;
        int bubble_bad = 0;
        present_mult();
        #1;
        for (int i = 1; i <= 34; i++) begin
            if (bus.ex_busy === 1'b1) busy_cycles++;
            tick();
            if (i < 34 && (bus.EX_MEM_wb !== 2'b00 || bus.EX_MEM_m !== 3'b000)) bubble_bad++;
        end
        tests++;
        if (busy_cycles != 33) begin
            fails++;
            $display("FAIL mult_busy_cycles: got %0d required 33", busy_cycles);
        end
        tests++;
        if (bubble_bad != 0) begin
            fails++;
            $display("FAIL mult_bubbles: got %0d non-bubble edges required 0", bubble_bad);
        end
        tests++;
        if (bus.EX_MEM_alu_result !== 32'hFFFF_FFEE || bus.EX_MEM_zero !== 1'b0 ||
            bus.EX_MEM_wb !== 2'b10 || bus.EX_MEM_rd !== 5'd7 || bus.EX_MEM_rdata2 !== 32'd6) begin
            fails++;
            $display("FAIL mult_result: got alu=%h z=%b wb=%b rd=%0d rd2=%h required ffffffee z=0 wb=10 rd=7 rd2=6",
                     bus.EX_MEM_alu_result, bus.EX_MEM_zero, bus.EX_MEM_wb, bus.EX_MEM_rd,
                     bus.EX_MEM_rdata2);
        end
        idle_inputs();
        #1;
        tests++;
        if (bus.ex_busy !== 1'b0) begin
            fails++;
            $display("FAIL mult_busy_after: got %b required 0", bus.ex_busy);
        end
        tick();
        tests++;
        if (bus.EX_MEM_wb !== 2'b00) begin
            fails++;
            $display("FAIL mult_single_emit: got wb=%b required 00", bus.EX_MEM_wb);
        end
    endtask

    task automatic test_flush();
        int late = 0;
        present_mult();
        for (int i = 1; i <= 9; i++) tick();
        bus.ex_flush = 1'b1;
        #1;
        tests++;
        if (bus.ex_busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy: got %b required 0", bus.ex_busy);
        end
        tick();
        tests++;
        if (bus.EX_MEM_wb !== 2'b00 || bus.EX_MEM_m !== 3'b000) begin
            fails++;
            $display("FAIL flush_bubble: got wb=%b m=%b required 00 000", bus.EX_MEM_wb, bus.EX_MEM_m);
        end
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.ex_busy !== 1'b0 || bus.EX_MEM_wb !== 2'b00) late++;
            tick();
        end
        tests++;
        if (late != 0) begin
            fails++;
            $display("FAIL flush_abort: got %0d cycles busy or emitting required 0", late);
        end
    endtask

    task automatic test_reset_mid_mult();
        int late = 0;
        present_mult();
        for (int i = 1; i <= 5; i++) tick();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tests++;
        if ({bus.EX_MEM_wb, bus.EX_MEM_m, bus.EX_MEM_add_result, bus.EX_MEM_zero,
             bus.EX_MEM_alu_result, bus.EX_MEM_rdata2, bus.EX_MEM_rd} !== '0 ||
            bus.ex_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_mult: got wb=%b m=%b alu=%h busy=%b required all 0",
                     bus.EX_MEM_wb, bus.EX_MEM_m, bus.EX_MEM_alu_result, bus.ex_busy);
        end
        rst_n = 1'b1;
        present(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd5, 32'd7,
                32'h0000_0020, 5'd3, 5'd9);
        tick();
        tests++;
        if (bus.EX_MEM_alu_result !== 32'd12 || bus.EX_MEM_wb !== 2'b10) begin
            fails++;
            $display("FAIL add_after_reset: got alu=%h wb=%b required 0000000c wb=10",
                     bus.EX_MEM_alu_result, bus.EX_MEM_wb);
        end
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ex_busy !== 1'b0 || bus.EX_MEM_wb !== 2'b00) late++;
        end
        tests++;
        if (late != 0) begin
            fails++;
            $display("FAIL reset_no_late_result: got %0d cycles busy or emitting required 0", late);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_add();
        test_branch();
        test_slt();
        test_back_to_back();
        test_mult();
        test_flush();
        test_reset_mid_mult();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
